// File: rtl/beam_thresh_loader_pkg.sv
// Shared constants and FSM state encoding for the beam threshold loader.
package beam_thresh_loader_pkg;

    localparam int unsigned TBITS = 18;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } ld_state_e;

endpackage

// File: rtl/thresh_stage_ram.sv
// Two-bank threshold staging memory: one write port, one registered read port
// that returns both banks side by side as {bank1, bank0}.
module thresh_stage_ram #(
    parameter int unsigned NBEAMS = 48,
    parameter int unsigned TBITS  = 18,
    parameter int unsigned IW     = $clog2(NBEAMS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic                 wr_sel_i,
    input  logic [IW-1:0]        wr_addr_i,
    input  logic [TBITS-1:0]     wr_dat_i,
    input  logic                 rd_en_i,
    input  logic [IW-1:0]        rd_addr_i,
    output logic [2*TBITS-1:0]   rd_dat_o
);

    logic [TBITS-1:0] bank0 [NBEAMS];
    logic [TBITS-1:0] bank1 [NBEAMS];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            if (wr_sel_i) begin
                bank1[wr_addr_i] <= wr_dat_i;
            end else begin
                bank0[wr_addr_i] <= wr_dat_i;
            end
        end
    end

    // Registered read; this register drives the cascade data bus directly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_dat_o <= '0;
        end else if (rd_en_i) begin
            rd_dat_o <= {bank1[rd_addr_i], bank0[rd_addr_i]};
        end
    end

endmodule

// File: rtl/beam_thresh_loader.sv
// Threshold sequencer: stages host-written thresholds and serially shifts the
// whole table into the dual-beam threshold cascade, then commits it.
module beam_thresh_loader #(
    parameter int unsigned NBEAMS = 48,
    parameter int unsigned TBITS  = beam_thresh_loader_pkg::TBITS,
    parameter int unsigned AW     = $clog2(NBEAMS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_wr_i,
    input  logic                 cfg_sel_i,
    input  logic [AW-1:0]        cfg_addr_i,
    input  logic [TBITS-1:0]     cfg_dat_i,
    input  logic                 load_i,
    input  logic [1:0]           load_mask_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [2*TBITS-1:0]   thresh_o,
    output logic [1:0]           thresh_wr_o,
    output logic [1:0]           thresh_update_o
);

    import beam_thresh_loader_pkg::*;

    localparam int unsigned     IW        = $clog2(NBEAMS);
    localparam logic [AW:0]     NB_W      = (AW+1)'(NBEAMS);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(NBEAMS - 1);

    ld_state_e       state_q;
    logic [AW-1:0]   cnt_q;
    logic [1:0]      mask_q;

    logic            idle_c;
    logic            addr_ok_c;
    logic            load_ok_c;
    logic            wr_ok_c;
    logic            err_set_c;
    logic            rd_en_c;
    logic [AW-1:0]   rd_addr_c;

    // Command acceptance and read-port steering.
    always_comb begin
        idle_c    = (state_q == ST_IDLE);
        addr_ok_c = ({1'b0, cfg_addr_i} < NB_W);
        // A load coinciding with the done pulse of a mask-00 load is refused too.
        load_ok_c = load_i && idle_c && !done_o;
        wr_ok_c   = cfg_wr_i && idle_c && addr_ok_c;
        err_set_c = (cfg_wr_i && !wr_ok_c) || (load_i && !load_ok_c);
        // PRIME reads the top entry; SHIFT pre-reads the entry after the one on the bus.
        rd_en_c   = (state_q == ST_PRIME) || ((state_q == ST_SHIFT) && (cnt_q != '0));
        rd_addr_c = cnt_q;
        if (state_q == ST_SHIFT && cnt_q != '0) begin
            rd_addr_c = cnt_q - AW'(1);
        end
    end

    // Load sequencer with registered outputs; cnt_q is the beam currently on thresh_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            mask_q          <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
            thresh_wr_o     <= '0;
            thresh_update_o <= '0;
        end else begin
            err_o           <= (err_o && !load_ok_c) || err_set_c;
            done_o          <= 1'b0;
            thresh_wr_o     <= '0;
            thresh_update_o <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (load_ok_c) begin
                        if (load_mask_i == 2'b00) begin
                            done_o <= 1'b1;
                        end else begin
                            state_q <= ST_PRIME;
                            busy_o  <= 1'b1;
                            mask_q  <= load_mask_i;
                            cnt_q   <= LAST_ADDR;
                        end
                    end
                end
                ST_PRIME: begin
                    state_q     <= ST_SHIFT;
                    thresh_wr_o <= mask_q;
                end
                ST_SHIFT: begin
                    if (cnt_q == '0) begin
                        state_q         <= ST_COMMIT;
                        thresh_update_o <= mask_q;
                    end else begin
                        cnt_q       <= cnt_q - AW'(1);
                        thresh_wr_o <= mask_q;
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_DONE;
                    done_o  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    thresh_stage_ram #(
        .NBEAMS (NBEAMS),
        .TBITS  (TBITS),
        .IW     (IW)
    ) u_stage_ram (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (wr_ok_c),
        .wr_sel_i  (cfg_sel_i),
        .wr_addr_i (IW'(cfg_addr_i)),
        .wr_dat_i  (cfg_dat_i),
        .rd_en_i   (rd_en_c),
        .rd_addr_i (IW'(rd_addr_c)),
        .rd_dat_o  (thresh_o)
    );

endmodule

// File: tb/tb_beam_thresh_loader.sv
// Directed bench for beam_thresh_loader with a 4-beam cascade model.
module tb_beam_thresh_loader;

    localparam int unsigned NB = 4;
    localparam int unsigned TB = 18;
    localparam int unsigned AW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_wr;
    logic            cfg_sel;
    logic [AW-1:0]   cfg_addr;
    logic [TB-1:0]   cfg_dat;
    logic            load;
    logic [1:0]      load_mask;
    logic            busy;
    logic            done;
    logic            err;
    logic [2*TB-1:0] thresh;
    logic [1:0]      thresh_wr;
    logic [1:0]      thresh_upd;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int wr_cnt = 0;

    logic [TB-1:0] sh0 [NB];
    logic [TB-1:0] sh1 [NB];
    logic [TB-1:0] act0 [NB];
    logic [TB-1:0] act1 [NB];

    beam_thresh_loader #(.NBEAMS(NB), .TBITS(TB), .AW(AW)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cfg_wr_i        (cfg_wr),
        .cfg_sel_i       (cfg_sel),
        .cfg_addr_i      (cfg_addr),
        .cfg_dat_i       (cfg_dat),
        .load_i          (load),
        .load_mask_i     (load_mask),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .thresh_o        (thresh),
        .thresh_wr_o     (thresh_wr),
        .thresh_update_o (thresh_upd)
    );

    always #5 clk = ~clk;

    // Cascade model: beam 0 receives the new word, older words move up.
    always @(negedge clk) begin
        if (thresh_wr != 2'b00) wr_cnt++;
        if (thresh_upd != 2'b00) upd_cnt++;
        if (thresh_wr[0]) begin
            for (int b = NB - 1; b > 0; b--) sh0[b] = sh0[b-1];
            sh0[0] = thresh[TB-1:0];
        end
        if (thresh_wr[1]) begin
            for (int b = NB - 1; b > 0; b--) sh1[b] = sh1[b-1];
            sh1[0] = thresh[2*TB-1:TB];
        end
        if (thresh_upd[0]) for (int b = 0; b < NB; b++) act0[b] = sh0[b];
        if (thresh_upd[1]) for (int b = 0; b < NB; b++) act1[b] = sh1[b];
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic sel, input int addr, input int dat);
        cfg_wr   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = AW'(addr);
        cfg_dat  = TB'(dat);
        tick();
        cfg_wr   = 1'b0;
    endtask

    task automatic chk_active(input int base0, input int base1);
        for (int b = 0; b < NB; b++) begin
            chk("act0", 64'(act0[b]), 64'(base0 + b));
            chk("act1", 64'(act1[b]), 64'(base1 + b));
        end
    endtask

    initial begin
        logic [2*TB-1:0] w;
        int wr_snap;
        int upd_snap;

        rst_n = 1'b0; cfg_wr = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_dat = '0;
        load = 1'b0; load_mask = 2'b00;
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_wr", 64'(thresh_wr), 64'(0));
        chk("rst_upd", 64'(thresh_upd), 64'(0));
        chk("rst_thresh", 64'(thresh), 64'(0));
        rst_n = 1'b1;
        tick();

        for (int b = 0; b < NB; b++) begin
            cfg(1'b0, b, 100 + b);
            cfg(1'b1, b, 200 + b);
        end

        // Full load, mask 11, with a load and a write attempted while busy.
        load = 1'b1; load_mask = 2'b11;
        tick();
        load = 1'b0;
        chk("full_c1_busy", 64'(busy), 64'(1));
        chk("full_c1_wr", 64'(thresh_wr), 64'(0));
        tick();
        for (int k = 0; k < NB; k++) begin
            w = {TB'(200 + NB - 1 - k), TB'(100 + NB - 1 - k)};
            chk("full_wr", 64'(thresh_wr), 64'(2'b11));
            chk("full_word", 64'(thresh), 64'(w));
            if (k == 2) chk("busy_err", 64'(err), 64'(1));
            if (k == 1) begin
                load = 1'b1; load_mask = 2'b11;
                cfg_wr = 1'b1; cfg_sel = 1'b0; cfg_addr = '0; cfg_dat = TB'(999);
            end
            tick();
            load = 1'b0; cfg_wr = 1'b0;
        end
        chk("full_c6_upd", 64'(thresh_upd), 64'(2'b11));
        chk("full_c6_wr", 64'(thresh_wr), 64'(0));
        tick();
        chk("full_c7_done", 64'(done), 64'(1));
        chk("full_c7_busy", 64'(busy), 64'(1));
        tick();
        chk("full_c8_busy", 64'(busy), 64'(0));
        chk("full_c8_done", 64'(done), 64'(0));
        chk("full_upd_cnt", 64'(upd_cnt), 64'(1));
        chk_active(100, 200);

        // Mask 00: clears err, pulses done next cycle, no cascade activity.
        wr_snap = wr_cnt; upd_snap = upd_cnt;
        load = 1'b1; load_mask = 2'b00;
        tick();
        load = 1'b0;
        chk("m0_done", 64'(done), 64'(1));
        chk("m0_err", 64'(err), 64'(0));
        chk("m0_busy", 64'(busy), 64'(0));
        tick();
        chk("m0_done_off", 64'(done), 64'(0));
        chk("m0_wr_cnt", 64'(wr_cnt), 64'(wr_snap));
        chk("m0_upd_cnt", 64'(upd_cnt), 64'(upd_snap));

        // Out-of-range address write.
        cfg(1'b0, 5, 777);
        chk("addr5_err", 64'(err), 64'(1));

        // Partial load, mask 01, with a new type1 table staged.
        for (int b = 0; b < NB; b++) cfg(1'b1, b, 300 + b);
        load = 1'b1; load_mask = 2'b01;
        tick();
        load = 1'b0;
        chk("part_c1_err", 64'(err), 64'(0));
        chk("part_c1_busy", 64'(busy), 64'(1));
        tick();
        for (int k = 0; k < NB; k++) begin
            w = {TB'(300 + NB - 1 - k), TB'(100 + NB - 1 - k)};
            chk("part_wr", 64'(thresh_wr), 64'(2'b01));
            chk("part_word", 64'(thresh), 64'(w));
            tick();
        end
        chk("part_c6_upd", 64'(thresh_upd), 64'(2'b01));
        tick();
        chk("part_c7_done", 64'(done), 64'(1));
        load = 1'b1; load_mask = 2'b11;
        tick();
        load = 1'b0;
        chk("done_load_err", 64'(err), 64'(1));
        chk("part_c8_busy", 64'(busy), 64'(0));
        tick();
        chk("done_load_ignored", 64'(busy), 64'(0));
        chk("part_upd_cnt", 64'(upd_cnt), 64'(2));
        chk_active(100, 200);

        // Reset in cycle 3 of a load: nothing committed.
        for (int b = 0; b < NB; b++) begin
            cfg(1'b0, b, 400 + b);
            cfg(1'b1, b, 500 + b);
        end
        load = 1'b1; load_mask = 2'b11;
        tick();
        load = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_wr", 64'(thresh_wr), 64'(0));
        chk("mid_rst_upd", 64'(thresh_upd), 64'(0));
        chk("mid_rst_err", 64'(err), 64'(0));
        chk("mid_rst_thresh", 64'(thresh), 64'(0));
        tick();
        chk("held_rst_wr", 64'(thresh_wr), 64'(0));
        chk("held_rst_done", 64'(done), 64'(0));
        rst_n = 1'b1;
        tick();
        chk("rst_upd_cnt", 64'(upd_cnt), 64'(2));
        chk_active(100, 200);

        // Fresh full load after reset.
        load = 1'b1; load_mask = 2'b11;
        tick();
        load = 1'b0;
        chk("re_c1_busy", 64'(busy), 64'(1));
        tick();
        for (int k = 0; k < NB; k++) begin
            w = {TB'(500 + NB - 1 - k), TB'(400 + NB - 1 - k)};
            chk("re_wr", 64'(thresh_wr), 64'(2'b11));
            chk("re_word", 64'(thresh), 64'(w));
            tick();
        end
        chk("re_c6_upd", 64'(thresh_upd), 64'(2'b11));
        tick();
        chk("re_c7_done", 64'(done), 64'(1));
        tick();
        chk("re_c8_busy", 64'(busy), 64'(0));
        chk("re_upd_cnt", 64'(upd_cnt), 64'(3));
        chk_active(400, 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
